// File: rtl/rot_reservation_station_pkg.sv
// Shared types for the rotate/shift reservation station.
// The flush option is selected by ROT_RS_FLUSH_EN in the top module.
package rot_reservation_station_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned GPR_ADDR_W = 5;

    typedef struct packed {
        logic [4:0] mb;
        logic [4:0] me;
        logic       mask_insert;
        logic       alter_cr0;
        logic       shift_left;
    } rotate_decode_t;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } rot_rs_state_t;

    // The tag of a missing operand sits in the low RS_ID_WIDTH bits of value.
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] value;
    } rot_rs_operand_t;

    typedef struct packed {
        rot_rs_state_t         state;
        logic [GPR_ADDR_W-1:0] result_reg_addr;
        rotate_decode_t        control;
        rot_rs_operand_t       op1;
        rot_rs_operand_t       op2;
        rot_rs_operand_t       target;
    } rot_rs_entry_t;

    function automatic logic rs_all_present(input rot_rs_entry_t e);
        return e.op1.valid & e.op2.valid & e.target.valid;
    endfunction

endpackage

// File: rtl/rot_rs_operand.sv
// One operand slot of a reservation-station entry: issue load with CDB bypass,
// and CDB snooping for a missing value while the entry waits.
module rot_rs_operand
    import rot_reservation_station_pkg::*;
#(
    parameter int unsigned RS_ID_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   load_valid,
    input  logic [DATA_W-1:0]      load_value,
    input  logic                   snoop_en,
    input  logic                   cdb_valid,
    input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
    input  logic [DATA_W-1:0]      cdb_result,
    output rot_rs_operand_t        opnd,
    output logic                   valid_next_c
);

    rot_rs_operand_t opnd_n;
    logic            load_hit_c;
    logic            snoop_hit_c;

    always_comb begin
        opnd_n       = opnd;
        load_hit_c   = !load_valid && cdb_valid &&
                       (cdb_rs_id == load_value[RS_ID_WIDTH-1:0]);
        snoop_hit_c  = snoop_en && !opnd.valid && cdb_valid &&
                       (cdb_rs_id == opnd.value[RS_ID_WIDTH-1:0]);
        if (load) begin
            opnd_n.valid = load_valid | load_hit_c;
            opnd_n.value = load_hit_c ? cdb_result : load_value;
        end else if (snoop_hit_c) begin
            opnd_n.valid = 1'b1;
            opnd_n.value = cdb_result;
        end
        valid_next_c = opnd_n.valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opnd <= '0;
        end else begin
            opnd <= opnd_n;
        end
    end

endmodule

// File: rtl/rot_reservation_station.sv
// Reservation station feeding rot_unit: holds rotate instructions until operands
// arrive, issues the oldest ready one. Define ROT_RS_FLUSH_EN to add a flush input.
module rot_reservation_station
    import rot_reservation_station_pkg::*;
#(
    parameter int unsigned RS_ID_WIDTH = 5,
    parameter int unsigned RS_DEPTH    = 4,
    parameter int unsigned RS_OFFSET   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef ROT_RS_FLUSH_EN
    input  logic                   flush,
`endif
    input  logic                   issue_valid,
    output logic                   issue_ready,
    output logic [RS_ID_WIDTH-1:0] issue_rs_id,
    input  logic [GPR_ADDR_W-1:0]  issue_result_reg_addr,
    input  rotate_decode_t         issue_control,
    input  logic                   issue_op1_valid,
    input  logic                   issue_op2_valid,
    input  logic                   issue_target_valid,
    input  logic [DATA_W-1:0]      issue_op1,
    input  logic [DATA_W-1:0]      issue_op2,
    input  logic [DATA_W-1:0]      issue_target,
    input  logic                   cdb_valid,
    input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
    input  logic [DATA_W-1:0]      cdb_result,
    output logic                   dispatch_valid,
    input  logic                   dispatch_ready,
    output logic [RS_ID_WIDTH-1:0] dispatch_rs_id,
    output logic [GPR_ADDR_W-1:0]  dispatch_result_reg_addr,
    output logic [DATA_W-1:0]      dispatch_op1,
    output logic [DATA_W-1:0]      dispatch_op2,
    output logic [DATA_W-1:0]      dispatch_target,
    output rotate_decode_t         dispatch_control
);

    localparam int unsigned IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    rot_rs_state_t         state_q [RS_DEPTH];
    rot_rs_state_t         state_n [RS_DEPTH];
    logic [GPR_ADDR_W-1:0] rrd_q   [RS_DEPTH];
    rotate_decode_t        ctrl_q  [RS_DEPTH];
    rot_rs_operand_t       op1_q   [RS_DEPTH];
    rot_rs_operand_t       op2_q   [RS_DEPTH];
    rot_rs_operand_t       tgt_q   [RS_DEPTH];
    rot_rs_entry_t         ent_c   [RS_DEPTH];

    // age_q[j][i] set means entry j was allocated before entry i
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_q, age_n;

    logic [RS_DEPTH-1:0] op1_vn, op2_vn, tgt_vn, all_vn;
    logic [RS_DEPTH-1:0] free_c, ready_c, wait_c, sel_c, alloc_c;
    logic [IDX_W-1:0]    free_idx_c;
    logic                any_free_c;
    logic                flush_c;

`ifdef ROT_RS_FLUSH_EN
    assign flush_c = flush;
`else
    assign flush_c = 1'b0;
`endif

    assign all_vn = op1_vn & op2_vn & tgt_vn;

    always_comb begin
        for (int i = 0; i < int'(RS_DEPTH); i++) begin
            ent_c[i] = '{state: state_q[i], result_reg_addr: rrd_q[i],
                         control: ctrl_q[i], op1: op1_q[i], op2: op2_q[i],
                         target: tgt_q[i]};
            free_c[i]  = (ent_c[i].state == FREE);
            wait_c[i]  = (ent_c[i].state == WAIT);
            ready_c[i] = (ent_c[i].state == READY);
        end
    end

    // Lowest free entry takes the next issue
    always_comb begin
        free_idx_c = '0;
        any_free_c = 1'b0;
        for (int i = int'(RS_DEPTH) - 1; i >= 0; i--) begin
            if (free_c[i]) begin
                free_idx_c = IDX_W'(i);
                any_free_c = 1'b1;
            end
        end
    end

    assign issue_ready = any_free_c && !rst && !flush_c;
    assign issue_rs_id = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(free_idx_c);

    always_comb begin
        for (int i = 0; i < int'(RS_DEPTH); i++) begin
            alloc_c[i] = issue_valid && issue_ready && (free_idx_c == IDX_W'(i));
        end
    end

    // Oldest ready entry wins; diagonal of the age matrix is always clear
    always_comb begin
        for (int i = 0; i < int'(RS_DEPTH); i++) begin
            sel_c[i] = ready_c[i] && !flush_c;
            for (int j = 0; j < int'(RS_DEPTH); j++) begin
                if (ready_c[j] && age_q[j][i]) begin
                    sel_c[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        dispatch_valid           = |sel_c;
        dispatch_rs_id           = '0;
        dispatch_result_reg_addr = '0;
        dispatch_control         = '0;
        dispatch_op1             = '0;
        dispatch_op2             = '0;
        dispatch_target          = '0;
        for (int i = 0; i < int'(RS_DEPTH); i++) begin
            if (sel_c[i]) begin
                dispatch_rs_id           = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(i);
                dispatch_result_reg_addr = ent_c[i].result_reg_addr;
                dispatch_control         = ent_c[i].control;
                dispatch_op1             = ent_c[i].op1.value;
                dispatch_op2             = ent_c[i].op2.value;
                dispatch_target          = ent_c[i].target.value;
            end
        end
    end

    // Per-entry next state and age update
    always_comb begin
        age_n = age_q;
        for (int i = 0; i < int'(RS_DEPTH); i++) begin
            state_n[i] = state_q[i];
            case (state_q[i])
                FREE:    if (alloc_c[i]) state_n[i] = all_vn[i] ? READY : WAIT;
                WAIT:    if (all_vn[i]) state_n[i] = READY;
                READY:   if (sel_c[i] && dispatch_ready) state_n[i] = FREE;
                default: state_n[i] = FREE;
            endcase
            if (flush_c) begin
                state_n[i] = FREE;
            end
            if (alloc_c[i]) begin
                for (int j = 0; j < int'(RS_DEPTH); j++) begin
                    age_n[i][j] = 1'b0;
                    age_n[j][i] = (j != i);
                end
            end
        end
        if (flush_c) begin
            age_n = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(RS_DEPTH); i++) begin
                state_q[i] <= FREE;
            end
            age_q <= '0;
        end else begin
            for (int i = 0; i < int'(RS_DEPTH); i++) begin
                state_q[i] <= state_n[i];
            end
            age_q <= age_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(RS_DEPTH); i++) begin
                rrd_q[i]  <= '0;
                ctrl_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(RS_DEPTH); i++) begin
                if (alloc_c[i]) begin
                    rrd_q[i]  <= issue_result_reg_addr;
                    ctrl_q[i] <= issue_control;
                end
            end
        end
    end

    // A READY entry must hold every operand value
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(RS_DEPTH); i++) begin
            if (ent_c[i].state == READY) begin
                assert (rs_all_present(ent_c[i]));
            end
        end
    end

    for (genvar g = 0; g < RS_DEPTH; g++) begin : g_entry
        rot_rs_operand #(.RS_ID_WIDTH(RS_ID_WIDTH)) u_op1 (
            .clk(clk), .rst(rst), .load(alloc_c[g]),
            .load_valid(issue_op1_valid), .load_value(issue_op1),
            .snoop_en(wait_c[g]), .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id),
            .cdb_result(cdb_result), .opnd(op1_q[g]), .valid_next_c(op1_vn[g])
        );
        rot_rs_operand #(.RS_ID_WIDTH(RS_ID_WIDTH)) u_op2 (
            .clk(clk), .rst(rst), .load(alloc_c[g]),
            .load_valid(issue_op2_valid), .load_value(issue_op2),
            .snoop_en(wait_c[g]), .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id),
            .cdb_result(cdb_result), .opnd(op2_q[g]), .valid_next_c(op2_vn[g])
        );
        rot_rs_operand #(.RS_ID_WIDTH(RS_ID_WIDTH)) u_tgt (
            .clk(clk), .rst(rst), .load(alloc_c[g]),
            .load_valid(issue_target_valid), .load_value(issue_target),
            .snoop_en(wait_c[g]), .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id),
            .cdb_result(cdb_result), .opnd(tgt_q[g]), .valid_next_c(tgt_vn[g])
        );
    end

endmodule

// File: tb/tb_rot_reservation_station.sv
// Scoreboard bench for rot_reservation_station: expected dispatches are queued by
// the stimulus and checked by an independent monitor on each dispatch handshake.
module tb_rot_reservation_station;
    import rot_reservation_station_pkg::*;

    localparam int unsigned W = 5;

    typedef struct packed {
        logic [W-1:0]   rs_id;
        logic [4:0]     rrd;
        rotate_decode_t ctrl;
        logic [31:0]    op1;
        logic [31:0]    op2;
        logic [31:0]    tgt;
    } disp_t;

    logic           clk;
    logic           rst;
    logic           issue_valid;
    logic           issue_ready;
    logic [W-1:0]   issue_rs_id;
    logic [4:0]     issue_result_reg_addr;
    rotate_decode_t issue_control;
    logic           issue_op1_valid, issue_op2_valid, issue_target_valid;
    logic [31:0]    issue_op1, issue_op2, issue_target;
    logic           cdb_valid;
    logic [W-1:0]   cdb_rs_id;
    logic [31:0]    cdb_result;
    logic           dispatch_valid;
    logic           dispatch_ready;
    logic [W-1:0]   dispatch_rs_id;
    logic [4:0]     dispatch_result_reg_addr;
    logic [31:0]    dispatch_op1, dispatch_op2, dispatch_target;
    rotate_decode_t dispatch_control;

    disp_t sb[$];
    int    vectors     = 0;
    int    miscompares = 0;

    rot_reservation_station #(.RS_ID_WIDTH(W), .RS_DEPTH(4), .RS_OFFSET(0)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rs_id(issue_rs_id),
        .issue_result_reg_addr(issue_result_reg_addr), .issue_control(issue_control),
        .issue_op1_valid(issue_op1_valid), .issue_op2_valid(issue_op2_valid),
        .issue_target_valid(issue_target_valid),
        .issue_op1(issue_op1), .issue_op2(issue_op2), .issue_target(issue_target),
        .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id), .cdb_result(cdb_result),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_rs_id(dispatch_rs_id), .dispatch_result_reg_addr(dispatch_result_reg_addr),
        .dispatch_op1(dispatch_op1), .dispatch_op2(dispatch_op2),
        .dispatch_target(dispatch_target), .dispatch_control(dispatch_control)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic disp_t mk(input int rs, input int rrd, input rotate_decode_t c,
                                 input logic [31:0] o1, input logic [31:0] o2,
                                 input logic [31:0] t);
        return '{rs_id: W'(rs), rrd: 5'(rrd), ctrl: c, op1: o1, op2: o2, tgt: t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int rrd, input rotate_decode_t c,
                         input logic v1, input logic [31:0] o1,
                         input logic v2, input logic [31:0] o2,
                         input logic vt, input logic [31:0] ot);
        issue_valid           = 1'b1;
        issue_result_reg_addr = 5'(rrd);
        issue_control         = c;
        issue_op1_valid       = v1;
        issue_op1             = o1;
        issue_op2_valid       = v2;
        issue_op2             = o2;
        issue_target_valid    = vt;
        issue_target          = ot;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic cdb(input int id, input logic [31:0] v);
        cdb_valid  = 1'b1;
        cdb_rs_id  = W'(id);
        cdb_result = v;
    endtask

    // Monitor: every accepted dispatch must match the oldest queued expectation
    always @(negedge clk) begin
        disp_t act, exp;
        if (!rst && dispatch_valid && dispatch_ready) begin
            act = '{rs_id: dispatch_rs_id, rrd: dispatch_result_reg_addr,
                    ctrl: dispatch_control, op1: dispatch_op1, op2: dispatch_op2,
                    tgt: dispatch_target};
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_dispatch: got %h, expected none", act);
            end else begin
                exp = sb.pop_front();
                if (act !== exp) begin
                    miscompares++;
                    $display("FAIL dispatch: got %h, expected %h", act, exp);
                end
            end
        end
    end

    rotate_decode_t c1, c2, c3;

    initial begin
        c1 = '{mb: 5'd16, me: 5'd28, mask_insert: 1'b1, alter_cr0: 1'b1, shift_left: 1'b0};
        c2 = '{mb: 5'd0,  me: 5'd31, mask_insert: 1'b0, alter_cr0: 1'b0, shift_left: 1'b1};
        c3 = '{mb: 5'd3,  me: 5'd7,  mask_insert: 1'b0, alter_cr0: 1'b1, shift_left: 1'b0};
        rst = 1'b1;
        issue_valid = 1'b0; issue_result_reg_addr = '0; issue_control = '0;
        issue_op1_valid = 1'b0; issue_op2_valid = 1'b0; issue_target_valid = 1'b0;
        issue_op1 = '0; issue_op2 = '0; issue_target = '0;
        cdb_valid = 1'b0; cdb_rs_id = '0; cdb_result = '0;
        dispatch_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_issue_ready", 32'(issue_ready), 32'd0);
        check("rst_dispatch_valid", 32'(dispatch_valid), 32'd0);
        check("rst_dispatch_op1", dispatch_op1, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_issue_ready", 32'(issue_ready), 32'd1);
        check("post_rst_issue_rs_id", 32'(issue_rs_id), 32'd0);

        // All operands present: dispatch in the very next cycle
        sb.push_back(mk(0, 31, c1, 32'h05E44C80, 32'd17, 32'hFFFF0000));
        issue(31, c1, 1'b1, 32'h05E44C80, 1'b1, 32'd17, 1'b1, 32'hFFFF0000);
        @(negedge clk);
        check("t1_dispatch_valid", 32'(dispatch_valid), 32'd1);
        check("t1_dispatch_rs_id", 32'(dispatch_rs_id), 32'd0);
        tick();
        @(negedge clk);
        check("t1_freed_valid", 32'(dispatch_valid), 32'd0);
        check("t1_freed_issue_ready", 32'(issue_ready), 32'd1);
        check("t1_freed_rs_id", 32'(issue_rs_id), 32'd0);

        // op2 waits on tag 7, arrives over the CDB three cycles later
        sb.push_back(mk(0, 3, c2, 32'h12345678, 32'd17, 32'h000000FF));
        issue(3, c2, 1'b1, 32'h12345678, 1'b0, 32'h7, 1'b1, 32'h000000FF);
        @(negedge clk);
        check("t2_waiting", 32'(dispatch_valid), 32'd0);
        tick();
        tick();
        cdb(7, 32'd17);
        @(negedge clk);
        check("t2_no_cdb_comb_path", 32'(dispatch_valid), 32'd0);
        tick();
        cdb_valid = 1'b0;
        @(negedge clk);
        check("t2_dispatch_valid", 32'(dispatch_valid), 32'd1);
        check("t2_dispatch_op2", dispatch_op2, 32'd17);
        tick();

        // Issue-time bypass of op1 from a concurrent broadcast
        sb.push_back(mk(0, 4, c3, 32'h05E44C80, 32'd5, 32'hAAAA5555));
        cdb(9, 32'h05E44C80);
        issue(4, c3, 1'b0, 32'h9, 1'b1, 32'd5, 1'b1, 32'hAAAA5555);
        cdb_valid = 1'b0;
        @(negedge clk);
        check("t3_dispatch_valid", 32'(dispatch_valid), 32'd1);
        check("t3_dispatch_op1", dispatch_op1, 32'h05E44C80);
        tick();

        // Fill while stalled; a fifth offer is ignored; drain in allocation order
        dispatch_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(mk(i, 10 + i, c1, 32'h100 + 32'(i), 32'(i), 32'hF0F00000 + 32'(i)));
            issue(10 + i, c1, 1'b1, 32'h100 + 32'(i), 1'b1, 32'(i), 1'b1, 32'hF0F00000 + 32'(i));
            if (i == 1) begin
                @(negedge clk);
                check("t4_lowest_free_id", 32'(issue_rs_id), 32'd2);
            end
        end
        @(negedge clk);
        check("t4_full_issue_ready", 32'(issue_ready), 32'd0);
        check("t4_stalled_rs_id", 32'(dispatch_rs_id), 32'd0);
        issue(20, c2, 1'b1, 32'hDEADBEEF, 1'b1, 32'd1, 1'b1, 32'd1);
        @(negedge clk);
        check("t4_still_full", 32'(issue_ready), 32'd0);
        check("t4_still_oldest", 32'(dispatch_rs_id), 32'd0);
        tick();
        dispatch_ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("t4_drained_valid", 32'(dispatch_valid), 32'd0);
        check("t4_drained_issue_ready", 32'(issue_ready), 32'd1);

        // Younger ready entry goes while the older one is still waiting
        sb.push_back(mk(1, 7, c2, 32'h3, 32'h4, 32'h5));
        sb.push_back(mk(0, 6, c3, 32'h0000ABCD, 32'h1, 32'h2));
        issue(6, c3, 1'b0, 32'h5, 1'b1, 32'h1, 1'b1, 32'h2);
        issue(7, c2, 1'b1, 32'h3, 1'b1, 32'h4, 1'b1, 32'h5);
        cdb(5, 32'h0000ABCD);
        @(negedge clk);
        check("t5_young_first", 32'(dispatch_rs_id), 32'd1);
        tick();
        cdb_valid = 1'b0;
        @(negedge clk);
        check("t5_old_next", 32'(dispatch_rs_id), 32'd0);
        tick();

        // Both ready while stalled: the older entry is selected
        dispatch_ready = 1'b0;
        sb.push_back(mk(0, 8, c1, 32'h11, 32'h22, 32'h33));
        sb.push_back(mk(1, 9, c1, 32'h44, 32'h55, 32'h66));
        issue(8, c1, 1'b1, 32'h11, 1'b0, 32'h6, 1'b1, 32'h33);
        issue(9, c1, 1'b1, 32'h44, 1'b1, 32'h55, 1'b1, 32'h66);
        @(negedge clk);
        check("t5b_only_young_ready", 32'(dispatch_rs_id), 32'd1);
        cdb(6, 32'h22);
        tick();
        cdb_valid = 1'b0;
        @(negedge clk);
        check("t5b_older_wins", 32'(dispatch_rs_id), 32'd0);
        tick();
        dispatch_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("t5b_drained", 32'(dispatch_valid), 32'd0);

        // Reset with occupied entries drops them immediately
        tick();
        dispatch_ready = 1'b0;
        issue(1, c1, 1'b1, 32'h1, 1'b1, 32'h1, 1'b1, 32'h1);
        issue(2, c1, 1'b1, 32'h2, 1'b1, 32'h2, 1'b1, 32'h2);
        issue(3, c1, 1'b0, 32'hC, 1'b1, 32'h3, 1'b1, 32'h3);
        @(negedge clk);
        check("t6_occupied_valid", 32'(dispatch_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_async_valid", 32'(dispatch_valid), 32'd0);
        check("t6_rst_issue_ready", 32'(issue_ready), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_released_issue_ready", 32'(issue_ready), 32'd1);
        check("t6_released_rs_id", 32'(issue_rs_id), 32'd0);
        cdb(12, 32'h77);
        tick();
        cdb_valid = 1'b0;
        @(negedge clk);
        check("t6_old_tag_ignored", 32'(dispatch_valid), 32'd0);
        tick();
        dispatch_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("final_valid", 32'(dispatch_valid), 32'd0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
